buf_dist: RTL and testbench
===========================

BUF_DIST -- requirements
Module: buf_dist

Interface
REQ-001 The block SHALL have parameter W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter N, default 2, number of output channels (N >= 1).
REQ-003 The block SHALL have parameter D, default 7, log2 of per-channel FIFO depth (depth 2**D words).
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port rst_fifo  input  N  synchronous per-channel flush.
REQ-007 The block SHALL have port v_i  input  1  input word valid.
REQ-008 The block SHALL have port d_i  input  W  input data word.
REQ-009 The block SHALL have port eof_i  input  1  input word is last of frame.
REQ-010 The block SHALL have port sel_i  input  $clog2(N+1)  destination channel, sampled on first word of frame.
REQ-011 The block SHALL have port rdy_o  output  1  block accepts input word this cycle.
REQ-012 The block SHALL have port rd  input  N  per-channel read request.
REQ-013 The block SHALL have port v_o  output  N  per-channel output word valid.
REQ-014 The block SHALL have port d_o  output  N x W  per-channel output data.
REQ-015 The block SHALL have port eof_o  output  N  per-channel last word of frame.
REQ-016 The block SHALL have port avl  output  N  channel FIFO non-empty.
REQ-017 The block SHALL have port drop_cnt  output  16  count of dropped frames.

Function
REQ-018 An input word SHALL transfer only in a cycle where v_i and rdy_o are both 1.
REQ-019 The FSM SHALL have states IDLE, FWD, DROP; reset state IDLE.
REQ-020 In IDLE, rdy_o SHALL be 1 if sel_i >= N, else equal to !full of channel sel_i.
REQ-021 In IDLE, a transfer with sel_i < N SHALL write {eof_i,d_i} to FIFO sel_i, latch dest = sel_i, and move to FWD unless eof_i = 1.
REQ-022 In IDLE, a transfer with sel_i >= N SHALL discard the word, increment drop_cnt, and move to DROP unless eof_i = 1.
REQ-023 In FWD, sel_i SHALL be ignored, rdy_o SHALL equal !full of dest, and each transfer SHALL write FIFO dest; a transfer with eof_i = 1 SHALL return to IDLE.
REQ-024 In DROP, rdy_o SHALL be 1, words SHALL be discarded, and a transfer with eof_i = 1 SHALL return to IDLE.
REQ-025 A write SHALL be blocked when the FIFO is full, even if that FIFO is read in the same cycle.
REQ-026 A read of channel i SHALL occur when rd[i] = 1 and the FIFO is non-empty; v_o[i] SHALL be 1 exactly one cycle later, with d_o[i] and eof_o[i] valid in that cycle.
REQ-027 rd[i] on an empty FIFO SHALL be ignored and v_o[i] SHALL be 0 next cycle.
REQ-028 avl[i] SHALL equal !empty of FIFO i, combinationally.
REQ-029 drop_cnt SHALL saturate at 16'hFFFF.
REQ-030 rst_fifo[i] SHALL empty FIFO i next cycle and force v_o[i] = 0; it SHALL take priority over a same-cycle read or write of channel i.
REQ-031 rst_fifo[dest] asserted in FWD SHALL move the FSM to DROP, increment drop_cnt, and discard the remaining words of the frame; a same-cycle eof_i transfer SHALL go to IDLE instead.

Reset
REQ-032 Asynchronous rst SHALL immediately set the state to IDLE, dest to 0, v_o to 0, eof_o to 0, drop_cnt to 0, and all FIFOs to empty; d_o SHALL be don't-care.
REQ-033 rst asserted mid-frame SHALL discard the partial frame; after release, the next valid word SHALL be treated as a first word.

Structure
REQ-034 Package buf_dist_pkg SHALL hold the FSM state enum and the drop-counter width constant (16).
REQ-035 Each channel SHALL instantiate sub-module fifo_sc_no_if with depth D and width W+1, in a generate loop.

Verification
REQ-036 Test: N=2; frame of 3 words 0x11,0x22,0x33 with sel_i=1, then rd[1] held high -> FIFO 1 gets 3 words, v_o[1] is high for 3 cycles starting 1 cycle after the first read, eof_o[1]=1 only on 0x33, FIFO 0 untouched.
REQ-037 Test: sel_i=2 (>= N), 4-word frame -> rdy_o=1 throughout, no FIFO written, drop_cnt 0->1.
REQ-038 Test: D=2; 6-word frame to ch0 with rd[0]=0 -> rdy_o falls after 4 words; rd[0] pulse -> one more word accepted next cycle.
REQ-039 Test: rst_fifo[0] during word 2 of a 5-word frame to ch0 -> FIFO 0 empty, avl[0]=0, words 3-5 discarded, drop_cnt +1, next frame to ch0 accepted normally.
REQ-040 Test: rst asserted mid-frame, released, then a 1-word frame (eof_i=1) with sel_i=0 -> written to ch0, FSM stays IDLE, drop_cnt=0.

Source files
------------

// File: rtl/buf_dist_pkg.sv
// Shared types and constants for the buffered frame distributor.
package buf_dist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  localparam int DROP_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_sc_no_if.sv
// Single-clock FIFO with registered read port; a flush empties it and wins over read/write.
module fifo_sc_no_if #(
  parameter int D = 7,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         rvalid,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [2**D];
  logic [D:0]   wptr;
  logic [D:0]   rptr;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[D] != rptr[D]) && (wptr[D-1:0] == rptr[D-1:0]);
  assign do_wr = wr && !full && !flush;
  assign do_rd = rd && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[D-1:0]] <= wdata;
    if (do_rd) rdata <= mem[rptr[D-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      rvalid <= 1'b0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      rvalid <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      rvalid <= do_rd;
    end
  end

endmodule

// File: rtl/buf_dist.sv
// Routes input frames to one of N per-channel FIFOs; frames to an invalid
// channel, or whose FIFO is flushed mid-frame, are dropped and counted.
module buf_dist
  import buf_dist_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 2,
  parameter int D = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            rst_fifo,
  input  logic                    v_i,
  input  logic [W-1:0]            d_i,
  input  logic                    eof_i,
  input  logic [$clog2(N+1)-1:0]  sel_i,
  output logic                    rdy_o,
  input  logic [N-1:0]            rd,
  output logic [N-1:0]            v_o,
  output logic [N*W-1:0]          d_o,
  output logic [N-1:0]            eof_o,
  output logic [N-1:0]            avl,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int SW = $clog2(N+1);

  state_t        state;
  logic [SW-1:0] dest;
  logic [N-1:0]  full;
  logic [N-1:0]  empty;
  logic          sel_ok;
  logic          sel_full;
  logic          dest_full;
  logic          dest_flush;
  logic          xfer;

  assign sel_ok = (sel_i < SW'(N));
  assign xfer   = v_i && rdy_o;
  assign avl    = ~empty;

  always_comb begin
    sel_full   = 1'b0;
    dest_full  = 1'b0;
    dest_flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SW'(i)) sel_full = full[i];
      if (dest == SW'(i)) begin
        dest_full  = full[i];
        dest_flush = rst_fifo[i];
      end
    end
  end

  always_comb begin
    case (state)
      IDLE:    rdy_o = sel_ok ? !sel_full : 1'b1;
      FWD:     rdy_o = !dest_full;
      default: rdy_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dest     <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (sel_ok) begin
              dest <= sel_i;
              if (!eof_i) state <= FWD;
            end else begin
              drop_cnt <= sat_inc(drop_cnt);
              if (!eof_i) state <= DROP;
            end
          end
        end
        FWD: begin
          // A flushed destination loses the rest of its frame.
          if (dest_flush) begin
            drop_cnt <= sat_inc(drop_cnt);
            state    <= (xfer && eof_i) ? IDLE : DROP;
          end else if (xfer && eof_i) begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (xfer && eof_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic         wr;
      logic [W:0]   q;
      logic         qv;

      assign wr = xfer && (((state == IDLE) && (sel_i == SW'(gi))) ||
                           ((state == FWD) && (dest == SW'(gi))));

      fifo_sc_no_if #(
        .D(D),
        .W(W+1)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rst_fifo[gi]),
        .wr    (wr),
        .wdata ({eof_i, d_i}),
        .rd    (rd[gi]),
        .rdata (q),
        .rvalid(qv),
        .empty (empty[gi]),
        .full  (full[gi])
      );

      assign v_o[gi]          = qv;
      assign eof_o[gi]        = qv && q[W];
      assign d_o[gi*W +: W]   = q[W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_buf_dist.sv
// Scoreboard bench for buf_dist with N=2, D=2 (4-word FIFOs).
module tb_buf_dist;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rst_fifo;
  logic        v_i;
  logic [7:0]  d_i;
  logic        eof_i;
  logic [1:0]  sel_i;
  logic        rdy_o;
  logic [1:0]  rd;
  logic [1:0]  v_o;
  logic [15:0] d_o;
  logic [1:0]  eof_o;
  logic [1:0]  avl;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  int exp_drop = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  buf_dist #(.W(8), .N(2), .D(2)) dut (
    .clk(clk), .rst(rst), .rst_fifo(rst_fifo), .v_i(v_i), .d_i(d_i),
    .eof_i(eof_i), .sel_i(sel_i), .rdy_o(rdy_o), .rd(rd), .v_o(v_o),
    .d_o(d_o), .eof_o(eof_o), .avl(avl), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Present one word for one cycle; report the rdy_o seen before the edge.
  task automatic send(input logic [1:0] sel, input logic [7:0] data, input logic eof,
                      output logic rdy_seen);
    v_i = 1'b1; sel_i = sel; d_i = data; eof_i = eof;
    #1 rdy_seen = rdy_o;
    @(posedge clk); #1;
    v_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic push(input int ch, input logic eof, input logic [7:0] data);
    if (ch == 0) q0.push_back({eof, data});
    else         q1.push_back({eof, data});
  endtask

  task automatic test_drain(input int ch, input int cycles);
    logic [8:0] exp;
    logic       ev;
    rd = '0;
    rd[ch] = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      exp = '0;
      if (ch == 0) ev = (q0.size() > 0);
      else         ev = (q1.size() > 0);
      if (ev) begin
        if (ch == 0) exp = q0.pop_front();
        else         exp = q1.pop_front();
      end
      @(posedge clk); #1;
      tests++;
      if (v_o[ch] !== ev) begin
        fails++;
        $display("FAIL drain_v ch%0d cyc%0d: got %b, expected %b", ch, c, v_o[ch], ev);
      end
      if (ev) begin
        tests++;
        if ({eof_o[ch], d_o[ch*8 +: 8]} !== exp) begin
          fails++;
          $display("FAIL drain_data ch%0d: got %h, expected %h", ch, {eof_o[ch], d_o[ch*8 +: 8]}, exp);
        end
      end
      $display("[TB] drain ch%0d cyc%0d v_o=%b d_o=%h eof_o=%b", ch, c, v_o[ch], d_o[ch*8 +: 8], eof_o[ch]);
    end
    rd = '0;
    tests++;
    if (avl[ch] !== 1'b0) begin
      fails++;
      $display("FAIL drain_avl ch%0d: got %b, expected 0", ch, avl[ch]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_fifo = '0; v_i = 1'b0; d_i = '0; eof_i = 1'b0; sel_i = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({v_o, eof_o, avl} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected 000000", {v_o, eof_o, avl});
    end
    tests++;
    if (drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt);
    end
    tests++;
    if (rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy: got %b, expected 1", rdy_o);
    end
    $display("[TB] reset v_o=%b avl=%b drop_cnt=%0d rdy_o=%b", v_o, avl, drop_cnt, rdy_o);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fwd();
    logic [7:0] words [3];
    logic       r;
    words = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      // sel_i only matters on the first word
      send((i == 0) ? 2'd1 : 2'd0, words[i], i == 2, r);
      tests++;
      if (r !== 1'b1) begin
        fails++;
        $display("FAIL fwd_rdy word%0d: got %b, expected 1", i, r);
      end
      push(1, i == 2, words[i]);
      $display("[TB] fwd word%0d d=%h rdy=%b", i, words[i], r);
    end
    tests++;
    if (avl !== 2'b10) begin
      fails++;
      $display("FAIL fwd_avl: got %b, expected 10", avl);
    end
    test_drain(1, 5);
  endtask

  task automatic test_drop();
    logic r;
    for (int i = 0; i < 4; i++) begin
      send(2'd2, 8'hC0 + 8'(i), i == 3, r);
      tests++;
      if (r !== 1'b1) begin
        fails++;
        $display("FAIL drop_rdy word%0d: got %b, expected 1", i, r);
      end
      $display("[TB] drop word%0d rdy=%b", i, r);
    end
    exp_drop++;
    tests++;
    if (avl !== 2'b00) begin
      fails++;
      $display("FAIL drop_avl: got %b, expected 00", avl);
    end
    tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      fails++;
      $display("FAIL drop_cnt: got %0d, expected %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_full();
    logic       r;
    logic [8:0] exp;
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 8'hA0 + 8'(i), 1'b0, r);
      tests++;
      if (r !== 1'b1) begin
        fails++;
        $display("FAIL full_rdy word%0d: got %b, expected 1", i, r);
      end
      push(0, 1'b0, 8'hA0 + 8'(i));
      $display("[TB] full word%0d rdy=%b", i, r);
    end
    send(2'd0, 8'hA4, 1'b0, r);
    tests++;
    if (r !== 1'b0) begin
      fails++;
      $display("FAIL full_stall: got %b, expected 0", r);
    end
    // Two passes: word 5 then the eof word 6, each unblocked by one read pulse.
    for (int k = 0; k < 2; k++) begin
      v_i = 1'b1; sel_i = 2'd0; d_i = 8'hA4 + 8'(k); eof_i = (k == 1);
      rd[0] = 1'b1;
      #1;
      tests++;
      if (rdy_o !== 1'b0) begin
        fails++;
        $display("FAIL full_rd_same_cycle k%0d: got %b, expected 0", k, rdy_o);
      end
      exp = q0.pop_front();
      @(posedge clk); #1;
      rd[0] = 1'b0;
      tests++;
      if (v_o[0] !== 1'b1 || {eof_o[0], d_o[7:0]} !== exp) begin
        fails++;
        $display("FAIL full_pulse_read k%0d: got v=%b %h, expected v=1 %h", k, v_o[0], {eof_o[0], d_o[7:0]}, exp);
      end
      tests++;
      if (rdy_o !== 1'b1) begin
        fails++;
        $display("FAIL full_after_read k%0d: got %b, expected 1", k, rdy_o);
      end
      push(0, k == 1, 8'hA4 + 8'(k));
      @(posedge clk); #1;
      v_i = 1'b0; eof_i = 1'b0;
      tests++;
      if (rdy_o !== 1'b0) begin
        fails++;
        $display("FAIL full_refilled k%0d: got %b, expected 0", k, rdy_o);
      end
      $display("[TB] full pulse k%0d accepted d=%h", k, 8'hA4 + 8'(k));
    end
    test_drain(0, 6);
  endtask

  task automatic test_flush();
    logic r;
    send(2'd0, 8'hB1, 1'b0, r);
    push(0, 1'b0, 8'hB1);
    v_i = 1'b1; sel_i = 2'd0; d_i = 8'hB2; eof_i = 1'b0; rst_fifo = 2'b01;
    #1 r = rdy_o;
    @(posedge clk); #1;
    rst_fifo = '0; v_i = 1'b0;
    q0.delete();
    exp_drop++;
    tests++;
    if ({avl[0], v_o[0]} !== 2'b00) begin
      fails++;
      $display("FAIL flush_empty: got avl=%b v=%b, expected 0 0", avl[0], v_o[0]);
    end
    tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      fails++;
      $display("FAIL flush_drop_cnt: got %0d, expected %0d", drop_cnt, exp_drop);
    end
    for (int i = 3; i <= 5; i++) begin
      send(2'd0, 8'hB0 + 8'(i), i == 5, r);
      tests++;
      if (r !== 1'b1 || avl[0] !== 1'b0) begin
        fails++;
        $display("FAIL flush_discard word%0d: got rdy=%b avl=%b, expected 1 0", i, r, avl[0]);
      end
      $display("[TB] flush discard word%0d rdy=%b avl=%b", i, r, avl[0]);
    end
    for (int i = 0; i < 2; i++) begin
      send(2'd0, 8'hD0 + 8'(i), i == 1, r);
      push(0, i == 1, 8'hD0 + 8'(i));
    end
    tests++;
    if (avl !== 2'b01) begin
      fails++;
      $display("FAIL flush_next_frame_avl: got %b, expected 01", avl);
    end
    test_drain(0, 3);
  endtask

  task automatic test_rst_mid();
    logic r;
    send(2'd1, 8'hE0, 1'b0, r);
    send(2'd1, 8'hE1, 1'b0, r);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({avl, v_o} !== 4'b0 || drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rst_async: got avl=%b v=%b drop=%0d, expected 00 00 0", avl, v_o, drop_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete(); exp_drop = 0;
    send(2'd0, 8'h5A, 1'b1, r);
    push(0, 1'b1, 8'h5A);
    // A second single-word frame to ch1 lands there only if the FSM stayed IDLE.
    send(2'd1, 8'h6B, 1'b1, r);
    push(1, 1'b1, 8'h6B);
    tests++;
    if (avl !== 2'b11) begin
      fails++;
      $display("FAIL rst_mid_avl: got %b, expected 11", avl);
    end
    tests++;
    if (drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rst_mid_drop_cnt: got %0d, expected 0", drop_cnt);
    end
    $display("[TB] rst_mid avl=%b drop_cnt=%0d", avl, drop_cnt);
    test_drain(0, 2);
    test_drain(1, 2);
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_drop();
    test_full();
    test_flush();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
